// File: rtl/reg_wb_pkg.sv
// Shared constants, the write-request record and helpers for the register-file write-back path.
package reg_wb_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    function automatic logic is_x0(input logic [AW-1:0] rd);
        return rd == '0;
    endfunction
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bus bundle between the EX/MEM result paths, the issue stage and reg_wb_ctrl.
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface reg_wb_ctrl_if;
    import reg_wb_pkg::*;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            iss_set;
    logic [AW-1:0]   iss_rd;
    logic [NREG-1:0] pend_mask;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd;
    logic            we;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            byp1_hit;
    logic            byp2_hit;
    logic [XLEN-1:0] byp1_data;
    logic [XLEN-1:0] byp2_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_set, iss_rd,
`ifdef WB_BYPASS_EN
        input  rs1, rs2,
        output byp1_hit, byp2_hit, byp1_data, byp2_data,
`endif
        output ld_ready, pend_mask, a3, wd, we
    );

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, iss_set, iss_rd,
`ifdef WB_BYPASS_EN
        output rs1, rs2,
        input  byp1_hit, byp2_hit, byp1_data, byp2_data,
`endif
        input  ld_ready, pend_mask, a3, wd, we
    );
endinterface

// File: rtl/reg_wb_ctrl_fifo.sv
// wb_fifo: circular buffer of load write-back requests; pointers carry an extra wrap bit.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    wb_req_t       mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    // When full, a simultaneous pop frees the very slot the push lands in.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PW-2:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-2:0]] <= din;
    end
endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: ALU/load write-back arbiter, registered register-file write port and pending-load
// scoreboard. Define WB_BYPASS_EN to add combinational forwarding from the write port.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    reg_wb_ctrl_if.slave  wb
);
    wb_req_t         ld_req;
    wb_req_t         head;
    wb_req_t         sel;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ld_push;
    logic            ld_pop;
    logic            sel_valid;
    logic            we_q;
    logic [AW-1:0]   a3_q;
    logic [XLEN-1:0] wd_q;
    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_nxt;

    assign ld_req  = '{rd: wb.ld_rd, data: wb.ld_data};
    assign ld_push = wb.ld_valid && !fifo_full;
    assign ld_pop  = !wb.alu_valid && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_push),
        .pop   (ld_pop),
        .din   (ld_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sel_valid = wb.alu_valid || !fifo_empty;
    assign sel       = wb.alu_valid ? wb_req_t'{rd: wb.alu_rd, data: wb.alu_data} : head;

    // Set is applied after clear so a same-cycle re-dispatch keeps the register pending.
    always_comb begin
        pend_nxt = pend_q;
        if (ld_pop && !is_x0(head.rd))           pend_nxt[head.rd]   = 1'b0;
        if (wb.iss_set && !is_x0(wb.iss_rd))     pend_nxt[wb.iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd_q   <= '0;
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt;
            if (sel_valid && !is_x0(sel.rd)) begin
                we_q <= 1'b1;
                a3_q <= sel.rd;
                wd_q <= sel.data;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign wb.ld_ready  = !fifo_full;
    assign wb.we        = we_q;
    assign wb.a3        = a3_q;
    assign wb.wd        = wd_q;
    assign wb.pend_mask = pend_q;

`ifdef WB_BYPASS_EN
    assign wb.byp1_hit  = we_q && (a3_q == wb.rs1) && !is_x0(a3_q);
    assign wb.byp2_hit  = we_q && (a3_q == wb.rs2) && !is_x0(a3_q);
    assign wb.byp1_data = wd_q;
    assign wb.byp2_data = wd_q;
`endif
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: directed table, hand sequences and a random run against a queue model.
module tb_reg_wb_ctrl;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_wb_ctrl_if bus ();
    reg_wb_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .wb(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic        rdy_seen;

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] adat;
        logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
        logic        is;  logic [4:0] ird;
        logic        e_rdy; logic e_we; logic [4:0] e_a3; logic [31:0] e_wd; logic [31:0] e_pend;
    } vec_t;
    vec_t tab[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_pend = '0;
        m_we   = 1'b0;
        m_a3   = '0;
        m_wd   = '0;
    endtask

    // Called just after a falling edge: drive, check ready, advance model, clock, check outputs.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic is, input logic [4:0] ird);
        logic  rdy;
        mreq_t r;
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
        bus.ld_valid  = lv; bus.ld_rd  = lrd; bus.ld_data  = ldat;
        bus.iss_set   = is; bus.iss_rd = ird;
        #1;
        rdy = (mq.size() < DEPTH);
        rdy_seen = bus.ld_ready;
        chk("ld_ready", {63'd0, bus.ld_ready}, {63'd0, rdy});
        m_we = 1'b0;
        if (av) begin
            if (ard != 0) begin m_we = 1'b1; m_a3 = ard; m_wd = adat; end
        end else if (mq.size() > 0) begin
            r = mq.pop_front();
            if (r.rd != 0) begin m_we = 1'b1; m_a3 = r.rd; m_wd = r.data; m_pend[r.rd] = 1'b0; end
        end
        if (lv && rdy) mq.push_back('{rd: lrd, data: ldat});
        if (is && ird != 0) m_pend[ird] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("we", {63'd0, bus.we}, {63'd0, m_we});
        chk("a3", {59'd0, bus.a3}, {59'd0, m_a3});
        chk("wd", {32'd0, bus.wd}, {32'd0, m_wd});
        chk("pend_mask", {32'd0, bus.pend_mask}, {32'd0, m_pend});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input logic hold_ld_valid);
        rst = 1'b0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid = hold_ld_valid; bus.ld_rd = 5'd7; bus.ld_data = 32'hDEAD;
        bus.iss_set = 0; bus.iss_rd = 0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_we", {63'd0, bus.we}, 64'd0);
        chk("rst_a3", {59'd0, bus.a3}, 64'd0);
        chk("rst_wd", {32'd0, bus.wd}, 64'd0);
        chk("rst_pend", {32'd0, bus.pend_mask}, 64'd0);
        chk("rst_ld_ready", {63'd0, bus.ld_ready}, 64'd1);
        bus.ld_valid = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
`ifdef WB_BYPASS_EN
        bus.rs1 = 0; bus.rs2 = 0;
`endif
        //            av ard  adat          lv lrd ldat       is ird  rdy we a3 wd            pend
        tab[0]  = '{1, 3,  32'hA5A5_0001, 0, 0, 0,          0, 0,  1,  1, 3, 32'hA5A5_0001, 32'h0};
        tab[1]  = '{0, 0,  0,             0, 0, 0,          0, 0,  1,  0, 3, 32'hA5A5_0001, 32'h0};
        tab[2]  = '{0, 0,  0,             0, 0, 0,          1, 6,  1,  0, 3, 32'hA5A5_0001, 32'h40};
        tab[3]  = '{0, 0,  0,             1, 6, 32'h1234,   0, 0,  1,  0, 3, 32'hA5A5_0001, 32'h40};
        tab[4]  = '{0, 0,  0,             0, 0, 0,          0, 0,  1,  1, 6, 32'h1234,      32'h0};
        tab[5]  = '{1, 0,  32'hFF,        1, 0, 32'h77,     0, 0,  1,  0, 6, 32'h1234,      32'h0};
        tab[6]  = '{0, 0,  0,             0, 0, 0,          0, 0,  1,  0, 6, 32'h1234,      32'h0};
        tab[7]  = '{0, 0,  0,             0, 0, 0,          0, 0,  1,  0, 6, 32'h1234,      32'h0};
        tab[8]  = '{1, 9,  32'h99,        0, 0, 0,          1, 9,  1,  1, 9, 32'h99,        32'h200};
        tab[9]  = '{0, 0,  0,             1, 9, 32'hABC,    1, 10, 1,  0, 9, 32'h99,        32'h600};
        tab[10] = '{0, 0,  0,             0, 0, 0,          1, 9,  1,  1, 9, 32'hABC,       32'h600};
        tab[11] = '{0, 0,  0,             0, 0, 0,          0, 0,  1,  0, 9, 32'hABC,       32'h600};

        // Reset held with a load offered: nothing is accepted or written.
        @(negedge clk);
        do_reset(1'b1);
        repeat (2) idle();

        for (int i = 0; i < 12; i++) begin
            step(tab[i].av, tab[i].ard, tab[i].adat, tab[i].lv, tab[i].lrd, tab[i].ldat,
                 tab[i].is, tab[i].ird);
            chk($sformatf("tab%0d_rdy", i), {63'd0, rdy_seen}, {63'd0, tab[i].e_rdy});
            chk($sformatf("tab%0d_we", i), {63'd0, bus.we}, {63'd0, tab[i].e_we});
            chk($sformatf("tab%0d_a3", i), {59'd0, bus.a3}, {59'd0, tab[i].e_a3});
            chk($sformatf("tab%0d_wd", i), {32'd0, bus.wd}, {32'd0, tab[i].e_wd});
            chk($sformatf("tab%0d_pend", i), {32'd0, bus.pend_mask}, {32'd0, tab[i].e_pend});
        end

        // ALU starves the FIFO until it fills; loads then drain in order.
        do_reset(1'b0);
        step(1, 1, 32'h11, 1, 7, 32'h70, 0, 0);
        step(1, 1, 32'h12, 1, 8, 32'h80, 0, 0);
        step(1, 1, 32'h13, 1, 9, 32'h90, 0, 0);
        chk("starve_ready", {63'd0, rdy_seen}, 64'd0);
        chk("starve_a3", {59'd0, bus.a3}, 64'd1);
        idle();
        chk("drain1_a3", {59'd0, bus.a3}, 64'd7);
        chk("drain1_wd", {32'd0, bus.wd}, 64'h70);
        chk("drain1_ready", {63'd0, bus.ld_ready}, 64'd1);
        idle();
        chk("drain2_a3", {59'd0, bus.a3}, 64'd8);
        chk("drain2_we", {63'd0, bus.we}, 64'd1);
        idle();
        chk("drain_done_we", {63'd0, bus.we}, 64'd0);

`ifdef WB_BYPASS_EN
        step(1, 5, 32'h55, 0, 0, 0, 0, 0);
        bus.rs1 = 5; bus.rs2 = 0;
        #1;
        chk("byp1_hit", {63'd0, bus.byp1_hit}, 64'd1);
        chk("byp1_data", {32'd0, bus.byp1_data}, 64'h55);
        chk("byp2_hit", {63'd0, bus.byp2_hit}, 64'd0);
        idle();
        chk("byp1_after", {63'd0, bus.byp1_hit}, 64'd0);
        bus.rs1 = 0;
`endif

        // Asynchronous reset between edges while a write is on the port and loads are buffered.
        step(1, 4, 32'h44, 1, 13, 32'hD0, 1, 12);
        step(1, 4, 32'h45, 1, 14, 32'hE0, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_we", {63'd0, bus.we}, 64'd0);
        chk("arst_pend", {32'd0, bus.pend_mask}, 64'd0);
        chk("arst_ready", {63'd0, bus.ld_ready}, 64'd1);
        model_clear();
        bus.alu_valid = 0; bus.ld_valid = 0; bus.iss_set = 0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) idle();

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)));
        end
        repeat (3) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
